// File: rtl/otf_sd_converter.sv
// On-the-fly converter: turns an MSD-first radix-2 signed-digit stream into a
// two's-complement result without any carry propagation.
module otf_sd_converter #(
  parameter int N_DIGITS = 16,
  parameter int DISCARD  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                digit_valid,
  input  logic [1:0]          digit,
  output logic                digit_ready,
  output logic [N_DIGITS:0]   result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, CONVERT, DONE} state_t;

  localparam int MAX_COUNT = (N_DIGITS > DISCARD) ? N_DIGITS : DISCARD;
  localparam int CW        = $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] CONV_LAST  = CW'(N_DIGITS - 1);
  localparam logic [CW-1:0] FLUSH_LAST = (DISCARD > 0) ? CW'(DISCARD - 1) : '0;
  localparam state_t        FIRST_STATE = (DISCARD > 0) ? FLUSH : CONVERT;
  localparam logic [N_DIGITS:0] LSB_ONE = {{N_DIGITS{1'b0}}, 1'b1};

  state_t              state_q;
  logic [N_DIGITS:0]   q_q, qm_q, q_d, qm_d;
  logic [CW-1:0]       count_q;
  logic                ready_q, valid_q, busy_q;
  logic                accept;

  // Digit is encoded {plus, minus}; both-set collapses to zero. QM tracks Q-1
  // so a negative digit only needs to select QM instead of borrowing.
  always_comb begin
    accept = digit_valid && ready_q;
    q_d    = q_q << 1;
    qm_d   = (qm_q << 1) | LSB_ONE;
    if (digit == 2'b10) begin
      q_d  = (q_q << 1) | LSB_ONE;
      qm_d = q_q << 1;
    end else if (digit == 2'b01) begin
      q_d  = (qm_q << 1) | LSB_ONE;
      qm_d = qm_q << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      qm_q    <= '1;
      count_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start) begin
      state_q <= FIRST_STATE;
      q_q     <= '0;
      qm_q    <= '1;
      count_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        FLUSH: begin
          if (accept) begin
            if (count_q == FLUSH_LAST) begin
              state_q <= CONVERT;
              count_q <= '0;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        CONVERT: begin
          if (accept) begin
            q_q  <= q_d;
            qm_q <= qm_d;
            if (count_q == CONV_LAST) begin
              state_q <= DONE;
              count_q <= '0;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign digit_ready  = ready_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign result       = q_q;

endmodule

// File: tb/tb_otf_sd_converter.sv
// Scoreboard bench for otf_sd_converter: unit 0 has no discard, unit 1 drops
// three warm-up digits; a monitor per unit pops expected results on handshake.
module tb_otf_sd_converter;

  localparam int N = 4;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] X = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      start, dv, rr;
  logic [1:0][1:0] dig;
  wire  [1:0]      rdy, rv, busy;
  wire  [1:0][N:0] res;

  int assertCount = 0;
  int failCount   = 0;
  logic [N:0] expQ0[$];
  logic [N:0] expQ1[$];

  always #5 clk = ~clk;

  otf_sd_converter #(.N_DIGITS(N), .DISCARD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .digit_valid(dv[0]),
    .digit(dig[0]), .digit_ready(rdy[0]), .result(res[0]),
    .result_valid(rv[0]), .result_ready(rr[0]), .busy(busy[0])
  );

  otf_sd_converter #(.N_DIGITS(N), .DISCARD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .digit_valid(dv[1]),
    .digit(dig[1]), .digit_ready(rdy[1]), .result(res[1]),
    .result_valid(rv[1]), .result_ready(rr[1]), .busy(busy[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshake completes on the next rising edge, so both signals are stable here.
  always @(negedge clk) begin
    if (rv[0] && rr[0]) begin
      if (expQ0.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unit0 unexpected result: got 0x%0h, expected none", res[0]);
      end else begin
        checkOutput("unit0 result", res[0], expQ0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rv[1] && rr[1]) begin
      if (expQ1.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unit1 unexpected result: got 0x%0h, expected none", res[1]);
      end else begin
        checkOutput("unit1 result", res[1], expQ1.pop_front());
      end
    end
  end

  task automatic doStart(input int u);
    start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
  endtask

  task automatic sendDigit(input int u, input logic [1:0] d, input bit stall);
    bit acc;
    int cyc;
    if (stall) begin
      dv[u] = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    dv[u]  = 1'b1;
    dig[u] = d;
    acc    = 1'b0;
    cyc    = 0;
    while (!acc && cyc < 20) begin
      @(negedge clk);
      acc = rdy[u];
      @(posedge clk); #1;
      cyc++;
    end
    dv[u] = 1'b0;
    checkOutput("digit accepted", 32'(acc), 32'd1);
  endtask

  task automatic applyStimulus(input int u, input logic [15:0] seq, input int n, input bit stall);
    for (int k = 0; k < n; k++) begin
      sendDigit(u, seq[2*(n-1-k) +: 2], stall);
    end
  endtask

  task automatic waitDrain(input int u);
    int c = 0;
    while (((u == 0) ? expQ0.size() : expQ1.size()) > 0 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("scoreboard drained", (u == 0) ? expQ0.size() : expQ1.size(), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] seqs [3];
    logic [N:0] exps [3];

    rst_n = 1'b0;
    start = '0;
    dv    = '0;
    rr    = 2'b11;
    dig   = '0;

    #12;
    for (int u = 0; u < 2; u++) begin
      checkOutput("reset ready", rdy[u], 0);
      checkOutput("reset valid", rv[u], 0);
      checkOutput("reset busy", busy[u], 0);
      checkOutput("reset result", res[u], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back digits with latency and DONE-state checks.
    doStart(0);
    checkOutput("convert busy", busy[0], 1);
    checkOutput("convert ready", rdy[0], 1);
    expQ0.push_back(5'b00111);
    applyStimulus(0, {8'b0, P, Z, M, P}, 4, 1'b0);
    checkOutput("valid after last digit", rv[0], 1);
    checkOutput("busy low in done", busy[0], 0);
    checkOutput("ready low in done", rdy[0], 0);
    checkOutput("direct result 7", res[0], 5'b00111);
    waitDrain(0);

    seqs = '{{M, M, M, M}, {P, M, M, M}, {X, X, X, X}};
    exps = '{5'b10001, 5'b00001, 5'b00000};
    for (int t = 0; t < 3; t++) begin
      doStart(0);
      expQ0.push_back(exps[t]);
      applyStimulus(0, {8'b0, seqs[t]}, 4, 1'b0);
      waitDrain(0);
    end

    // Warm-up digits are consumed but must not affect the result.
    doStart(1);
    expQ1.push_back(5'b00010);
    for (int k = 0; k < 3; k++) begin
      checkOutput("flush ready", rdy[1], 1);
      checkOutput("flush busy", busy[1], 1);
      sendDigit(1, (k == 1) ? M : P, 1'b0);
    end
    applyStimulus(1, {8'b0, Z, Z, P, Z}, 4, 1'b0);
    waitDrain(1);

    // Stalled input and held-off result.
    rr[0] = 1'b0;
    doStart(0);
    expQ0.push_back(5'b00111);
    applyStimulus(0, {8'b0, P, Z, M, P}, 4, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("backpressure valid", rv[0], 1);
      checkOutput("backpressure result", res[0], 5'b00111);
      @(posedge clk); #1;
    end
    rr[0] = 1'b1;
    waitDrain(0);
    checkOutput("idle valid", rv[0], 0);
    checkOutput("idle ready", rdy[0], 0);

    // Restart partway through discards the earlier digits.
    doStart(0);
    sendDigit(0, P, 1'b0);
    sendDigit(0, P, 1'b0);
    doStart(0);
    expQ0.push_back(5'b11000);
    applyStimulus(0, {8'b0, M, Z, Z, Z}, 4, 1'b0);
    waitDrain(0);

    // Start while a result is pending drops it.
    rr[0] = 1'b0;
    doStart(0);
    applyStimulus(0, {8'b0, P, P, P, P}, 4, 1'b0);
    checkOutput("pending valid", rv[0], 1);
    checkOutput("pending result", res[0], 5'b01111);
    doStart(0);
    checkOutput("start in done drops valid", rv[0], 0);
    checkOutput("start in done busy", busy[0], 1);
    checkOutput("start in done clears result", res[0], 0);
    rr[0] = 1'b1;
    expQ0.push_back(5'b00001);
    applyStimulus(0, {8'b0, Z, Z, Z, P}, 4, 1'b0);
    waitDrain(0);

    // Asynchronous reset between edges mid-conversion.
    doStart(0);
    sendDigit(0, P, 1'b0);
    sendDigit(0, M, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset ready", rdy[0], 0);
    checkOutput("async reset busy", busy[0], 0);
    checkOutput("async reset valid", rv[0], 0);
    checkOutput("async reset result", res[0], 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    doStart(0);
    expQ0.push_back(5'b01111);
    applyStimulus(0, {8'b0, P, P, P, P}, 4, 1'b0);
    waitDrain(0);

    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
